// File: rtl/reg_bus_initiator_pkg.sv
// Shared definitions for the register-bus initiator: FSM encoding, counter
// width and the board register addresses used around it.
package reg_bus_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_GAP  = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_e;

  localparam int CNT_W = 8;

  localparam logic [15:0] ADDR_MAIN   = 16'h0000;
  localparam logic [15:0] REG_STATUS  = 16'h0000;
  localparam logic [15:0] REG_TIMEOUT = 16'h0003;
  localparam logic [15:0] REG_VERSION = 16'h0004;

  // A window of N cycles ends when the counter reaches zero, so load N-1.
  function automatic logic [CNT_W-1:0] lat_load_val(input int cycles);
    return (cycles > 0) ? CNT_W'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/reg_bus_initiator_if.sv
// Command, response and register-bus signals of the initiator.
// master = initiator side, slave = decoder/responder side.
interface reg_bus_initiator_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [15:0]      cmd_addr;
  logic [31:0]      cmd_wdata;
  logic [LEN_W-1:0] cmd_len;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic             rsp_last;
  logic [15:0]      reg_raddr;
  logic [15:0]      reg_waddr;
  logic [31:0]      reg_wdata;
  logic             reg_wen;
  logic [31:0]      reg_rdata;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, reg_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_last,
           reg_raddr, reg_waddr, reg_wdata, reg_wen, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, reg_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last,
           reg_raddr, reg_waddr, reg_wdata, reg_wen, busy
  );
endinterface

// File: rtl/reg_bus_initiator_lat_counter.sv
// Loadable down-counter; tc flags the final cycle of the loaded window.
module lat_counter
  import reg_bus_initiator_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && !tc) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/reg_bus_initiator.sv
// Register-bus master: serialises quadlet writes and (block) reads from the
// packet decoder onto the register-file bus, returning read data as strobes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a command
// ST_WR      | reg_wen high for this single cycle
// ST_WR_GAP  | reg_wen held low for WEN_GAP cycles before the next command
// ST_RD_ADDR | first latency cycle of a quadlet, reg_raddr just updated
// ST_RD_WAIT | remaining latency cycles; rdata sampled on the last one
module reg_bus_initiator
  import reg_bus_initiator_pkg::*;
#(
  parameter int RD_LAT  = 2,
  parameter int WEN_GAP = 1,
  parameter int LEN_W   = 8
) (
  input logic sysclk,
  input logic reset,
  reg_bus_initiator_if.master bus
);

  localparam logic [CNT_W-1:0] RD_LOAD  = lat_load_val(RD_LAT);
  localparam logic [CNT_W-1:0] GAP_LOAD = lat_load_val(WEN_GAP);

  state_e           state_d, state_q;
  logic [15:0]      waddr_d, waddr_q;
  logic [31:0]      wdata_d, wdata_q;
  logic [15:0]      raddr_d, raddr_q;
  logic [LEN_W-1:0] remaining_d, remaining_q;
  logic             rsp_valid_d, rsp_valid_q;
  logic             rsp_last_d, rsp_last_q;
  logic [31:0]      rsp_data_d, rsp_data_q;

  logic             lat_load;
  logic [CNT_W-1:0] lat_val;
  logic             lat_dec;
  logic             lat_tc;
  logic             cmd_ready;
  logic             accept;

  lat_counter #(.W(CNT_W)) u_lat (
    .clk      (sysclk),
    .rst      (reset),
    .load     (lat_load),
    .load_val (lat_val),
    .dec      (lat_dec),
    .tc       (lat_tc)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = cmd_ready && bus.cmd_valid;

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;
    remaining_d = remaining_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = rsp_data_q;
    lat_load    = 1'b0;
    lat_val     = '0;
    lat_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.cmd_write) begin
            waddr_d = bus.cmd_addr;
            wdata_d = bus.cmd_wdata;
            state_d = ST_WR;
          end else begin
            raddr_d     = bus.cmd_addr;
            remaining_d = bus.cmd_len;
            lat_load    = 1'b1;
            lat_val     = RD_LOAD;
            state_d     = ST_RD_ADDR;
          end
        end
      end

      ST_WR: begin
        if (WEN_GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          lat_load = 1'b1;
          lat_val  = GAP_LOAD;
          state_d  = ST_WR_GAP;
        end
      end

      ST_WR_GAP: begin
        if (lat_tc) begin
          state_d = ST_IDLE;
        end else begin
          lat_dec = 1'b1;
        end
      end

      ST_RD_ADDR, ST_RD_WAIT: begin
        if (lat_tc) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.reg_rdata;
          rsp_last_d  = (remaining_q == '0);
          if (remaining_q != '0) begin
            // Next quadlet: 16-bit address wraps naturally past 0xFFFF.
            raddr_d     = raddr_q + 16'd1;
            remaining_d = remaining_q - LEN_W'(1);
            lat_load    = 1'b1;
            lat_val     = RD_LOAD;
            state_d     = ST_RD_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          lat_dec = 1'b1;
          state_d = ST_RD_WAIT;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      remaining_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      remaining_q <= remaining_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // reg_wen decodes straight from the state flop so reset removes it at once.
  assign bus.reg_wen   = (state_q == ST_WR);
  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.reg_raddr = raddr_q;
  assign bus.reg_waddr = waddr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
